vlog_apb_master: RTL and testbench

// APB initiator that lets a coprocessor-side command port drive the peripheral
// APB bus that vlog_module-style slaves sit on. Accepts one read/write command
// at a time and decodes the slave index from the address. Runs the two-phase

---
 rtl/vlog_apb_master_if.sv | 30 +++
 rtl/vlog_apb_master.sv | 134 +++++++++++++
 tb/tb_vlog_apb_master.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/vlog_apb_master_if.sv
// rtl/vlog_apb_master_if.sv - command port plus APB bus signals for vlog_apb_master
interface vlog_apb_master_if #(
  parameter int vnapbslv = 8
);
  logic                  creq;
  logic                  cwrite;
  logic [31:0]           caddr;
  logic [31:0]           cwdata;
  logic                  cack;
  logic                  cdone;
  logic [31:0]           crdata;
  logic                  cerr;
  logic [0:vnapbslv-1]   vpsel;
  logic                  vpenable;
  logic [31:0]           vpaddr;
  logic                  vpwrite;
  logic [31:0]           vpwdata;
  logic [31:0]           vprdata;
  logic                  vpready;

  modport master (
    input  creq, cwrite, caddr, cwdata, vprdata, vpready,
    output cack, cdone, crdata, cerr, vpsel, vpenable, vpaddr, vpwrite, vpwdata
  );

  modport slave (
    output creq, cwrite, caddr, cwdata, vprdata, vpready,
    input  cack, cdone, crdata, cerr, vpsel, vpenable, vpaddr, vpwrite, vpwdata
  );
endinterface

// File: rtl/vlog_apb_master.sv
// rtl/vlog_apb_master.sv - single-outstanding command port to APB initiator
// SETUP/ACCESS sequencing with slave-index decode and wait-state timeout.
module vlog_apb_master #(
  parameter int vnapbslv = 8,
  parameter int vsel_lsb = 12,
  parameter int vtimeout = 16
) (
  input  logic              vclk,
  input  logic              vrst,
  vlog_apb_master_if.master bus
);

  localparam int              IW   = (vnapbslv > 1) ? $clog2(vnapbslv) : 1;
  localparam int              CW   = (vtimeout > 1) ? $clog2(vtimeout + 1) : 1;
  localparam logic [8:0]      NSLV = 9'(vnapbslv);
  localparam logic [CW-1:0]   TMO  = CW'(vtimeout);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [IW-1:0]       r_idx;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_write;
  logic                r_done;
  logic                r_err;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nx;
  logic [7:0]          w_idx8;
  logic                w_idx_ok;
  logic                w_accept;
  logic                w_done_nx;
  logic                w_err_nx;
  logic [31:0]         w_rdata_nx;
  logic [0:vnapbslv-1] w_psel;

  assign w_idx8   = bus.caddr[vsel_lsb+7:vsel_lsb];
  assign w_idx_ok = ({1'b0, w_idx8} < NSLV);
  // cack is held low while reset is asserted even though it is combinational
  assign w_accept = vrst && bus.creq && (r_state == S_IDLE);

  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_rdata_nx = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_idx_ok) begin
            w_state_nx = S_SETUP;
            w_cnt_nx   = '0;
          end else begin
            w_done_nx  = 1'b1;
            w_err_nx   = 1'b1;
            w_rdata_nx = '0;
          end
        end
      end
      S_SETUP: w_state_nx = S_ACCESS;
      S_ACCESS: begin
        if (bus.vpready) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
          if (!r_write) w_rdata_nx = bus.vprdata;
        end else if ((vtimeout != 0) && ((r_cnt + 1'b1) == TMO)) begin
          w_state_nx = S_IDLE;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
          w_rdata_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Bus latches only load for a decodable index so a rejected command leaves the bus untouched
  always_ff @(posedge vclk or negedge vrst) begin
    if (!vrst) begin
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
      r_rdata <= w_rdata_nx;
      r_cnt   <= w_cnt_nx;
      if (w_accept && w_idx_ok) begin
        r_idx   <= w_idx8[IW-1:0];
        r_addr  <= bus.caddr;
        r_wdata <= bus.cwdata;
        r_write <= bus.cwrite;
      end
    end
  end

  always_comb begin
    w_psel = '0;
    if (r_state != S_IDLE) w_psel[r_idx] = 1'b1;
  end

  assign bus.cack     = w_accept;
  assign bus.cdone    = r_done;
  assign bus.cerr     = r_err;
  assign bus.crdata   = r_rdata;
  assign bus.vpsel    = w_psel;
  assign bus.vpenable = (r_state == S_ACCESS);
  assign bus.vpaddr   = r_addr;
  assign bus.vpwrite  = r_write;
  assign bus.vpwdata  = r_wdata;

endmodule

// File: tb/tb_vlog_apb_master.sv
// tb/tb_vlog_apb_master.sv - directed bench for vlog_apb_master
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_vlog_apb_master;

  logic vclk;
  logic vrst;
  int   checks;
  int   errors;
  logic [0:7] e_sel;
  int   n_acc;

  vlog_apb_master_if #(.vnapbslv(8)) bus ();

  vlog_apb_master #(
    .vnapbslv(8),
    .vsel_lsb(12),
    .vtimeout(16)
  ) dut (
    .vclk(vclk),
    .vrst(vrst),
    .bus (bus.master)
  );

  initial begin
    vclk = 1'b0;
    forever #5 vclk = ~vclk;
  end

  task automatic cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.creq = 1'b1; bus.cwrite = wr; bus.caddr = a; bus.cwdata = d;
  endtask

  task automatic test_reset();
    vrst = 1'b0; bus.creq = 1'b1; bus.cwrite = 1'b0; bus.caddr = '0; bus.cwdata = '0;
    bus.vprdata = '0; bus.vpready = 1'b1;
    @(negedge vclk); #1;
    checks++; if (bus.cack !== 1'b0) begin errors++; $display("FAIL rst_cack got=%b exp=0", bus.cack); end
    checks++; if (bus.vpsel !== 8'h00) begin errors++; $display("FAIL rst_vpsel got=%b exp=00000000", bus.vpsel); end
    checks++; if (bus.vpenable !== 1'b0) begin errors++; $display("FAIL rst_vpenable got=%b exp=0", bus.vpenable); end
    checks++; if (bus.cdone !== 1'b0 || bus.cerr !== 1'b0) begin errors++; $display("FAIL rst_done_err got=%b%b exp=00", bus.cdone, bus.cerr); end
    checks++; if (bus.crdata !== 32'h0) begin errors++; $display("FAIL rst_crdata got=%h exp=00000000", bus.crdata); end
    checks++; if (bus.vpaddr !== 32'h0 || bus.vpwdata !== 32'h0 || bus.vpwrite !== 1'b0) begin errors++; $display("FAIL rst_bus got=%h/%h/%b exp=0/0/0", bus.vpaddr, bus.vpwdata, bus.vpwrite); end
    @(negedge vclk); vrst = 1'b1; bus.creq = 1'b0;
  endtask

  task automatic test_write();
    e_sel = '0; e_sel[2] = 1'b1;
    @(negedge vclk); cmd(1'b1, 32'h0000_2000, 32'hCAFE_F00D); bus.vpready = 1'b1; #1;
    checks++; if (bus.cack !== 1'b1) begin errors++; $display("FAIL wr_cack got=%b exp=1", bus.cack); end
    @(negedge vclk); bus.creq = 1'b0; #1;
    checks++; if (bus.vpsel !== e_sel || bus.vpenable !== 1'b0) begin errors++; $display("FAIL wr_setup got=%b/%b exp=%b/0", bus.vpsel, bus.vpenable, e_sel); end
    checks++; if (bus.vpaddr !== 32'h2000 || bus.vpwdata !== 32'hCAFE_F00D || bus.vpwrite !== 1'b1) begin errors++; $display("FAIL wr_setup_bus got=%h/%h/%b exp=00002000/cafef00d/1", bus.vpaddr, bus.vpwdata, bus.vpwrite); end
    @(negedge vclk); #1;
    checks++; if (bus.vpsel !== e_sel || bus.vpenable !== 1'b1 || bus.vpwrite !== 1'b1) begin errors++; $display("FAIL wr_access got=%b/%b/%b exp=%b/1/1", bus.vpsel, bus.vpenable, bus.vpwrite, e_sel); end
    checks++; if (bus.cdone !== 1'b0) begin errors++; $display("FAIL wr_early_done got=%b exp=0", bus.cdone); end
    @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b0) begin errors++; $display("FAIL wr_done got=%b/%b exp=1/0", bus.cdone, bus.cerr); end
    checks++; if (bus.vpsel !== 8'h00 || bus.vpenable !== 1'b0 || bus.vpaddr !== 32'h2000) begin errors++; $display("FAIL wr_idle_bus got=%b/%b/%h exp=0/0/00002000", bus.vpsel, bus.vpenable, bus.vpaddr); end
    checks++; if (bus.crdata !== 32'h0) begin errors++; $display("FAIL wr_crdata got=%h exp=00000000", bus.crdata); end
    @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got=%b exp=0", bus.cdone); end
  endtask

  task automatic test_read();
    e_sel = '0; e_sel[0] = 1'b1;
    @(negedge vclk); cmd(1'b0, 32'h0000_0004, 32'h0); bus.vprdata = 32'h5; bus.vpready = 1'b1; #1;
    checks++; if (bus.cack !== 1'b1) begin errors++; $display("FAIL rd_cack got=%b exp=1", bus.cack); end
    @(negedge vclk); bus.creq = 1'b0; #1;
    checks++; if (bus.vpsel !== e_sel || bus.vpwrite !== 1'b0 || bus.vpaddr !== 32'h4) begin errors++; $display("FAIL rd_setup got=%b/%b/%h exp=%b/0/00000004", bus.vpsel, bus.vpwrite, bus.vpaddr, e_sel); end
    @(negedge vclk); #1;
    checks++; if (bus.vpenable !== 1'b1 || bus.cdone !== 1'b0) begin errors++; $display("FAIL rd_access got=%b/%b exp=1/0", bus.vpenable, bus.cdone); end
    @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b0 || bus.crdata !== 32'h5) begin errors++; $display("FAIL rd_done got=%b/%b/%h exp=1/0/00000005", bus.cdone, bus.cerr, bus.crdata); end
  endtask

  task automatic test_wait_states();
    e_sel = '0; e_sel[3] = 1'b1;
    @(negedge vclk); cmd(1'b0, 32'h0000_3008, 32'h0); bus.vprdata = 32'h1234_5678; bus.vpready = 1'b0;
    @(negedge vclk); bus.creq = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge vclk);
      if (i == 3) bus.vpready = 1'b1;
      #1;
      if (bus.vpenable === 1'b1) n_acc++;
      checks++; if (bus.vpsel !== e_sel || bus.vpaddr !== 32'h3008 || bus.vpwrite !== 1'b0 || bus.cdone !== 1'b0) begin errors++; $display("FAIL ws_stable[%0d] got=%b/%h/%b/%b exp=%b/00003008/0/0", i, bus.vpsel, bus.vpaddr, bus.vpwrite, bus.cdone, e_sel); end
    end
    checks++; if (n_acc != 4) begin errors++; $display("FAIL ws_access_cycles got=%0d exp=4", n_acc); end
    @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b0 || bus.crdata !== 32'h1234_5678) begin errors++; $display("FAIL ws_done got=%b/%b/%h exp=1/0/12345678", bus.cdone, bus.cerr, bus.crdata); end
  endtask

  task automatic test_decode_error();
    @(negedge vclk); cmd(1'b1, 32'h0000_9010, 32'hDEAD_BEEF); bus.vpready = 1'b1; #1;
    checks++; if (bus.cack !== 1'b1) begin errors++; $display("FAIL dec_cack got=%b exp=1", bus.cack); end
    @(negedge vclk); bus.creq = 1'b0; #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b1 || bus.crdata !== 32'h0) begin errors++; $display("FAIL dec_done got=%b/%b/%h exp=1/1/00000000", bus.cdone, bus.cerr, bus.crdata); end
    checks++; if (bus.vpsel !== 8'h00 || bus.vpenable !== 1'b0) begin errors++; $display("FAIL dec_bus got=%b/%b exp=00000000/0", bus.vpsel, bus.vpenable); end
    @(negedge vclk); #1;
    checks++; if (bus.vpsel !== 8'h00 || bus.cdone !== 1'b0 || bus.cerr !== 1'b0) begin errors++; $display("FAIL dec_after got=%b/%b/%b exp=00000000/0/0", bus.vpsel, bus.cdone, bus.cerr); end
  endtask

  task automatic test_timeout();
    bit seen;
    @(negedge vclk); cmd(1'b0, 32'h0000_7000, 32'h0); bus.vprdata = 32'hFFFF_FFFF; bus.vpready = 1'b0;
    @(negedge vclk); bus.creq = 1'b0;
    n_acc = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge vclk); #1;
      if (bus.vpenable === 1'b1) n_acc++;
      if (bus.cdone === 1'b1) begin
        seen = 1'b1;
        checks++; if (bus.cerr !== 1'b1 || bus.crdata !== 32'h0 || bus.vpsel !== 8'h00) begin errors++; $display("FAIL to_done got=%b/%h/%b exp=1/00000000/00000000", bus.cerr, bus.crdata, bus.vpsel); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_no_done got=0 exp=1 within 40 cycles"); end
    checks++; if (n_acc != 16) begin errors++; $display("FAIL to_access_cycles got=%0d exp=16", n_acc); end
    bus.vpready = 1'b1;
  endtask

  task automatic test_back_to_back();
    e_sel = '0; e_sel[1] = 1'b1;
    @(negedge vclk); cmd(1'b0, 32'h0000_1000, 32'h0); bus.vprdata = 32'h0000_00A5; bus.vpready = 1'b1; #1;
    checks++; if (bus.cack !== 1'b1) begin errors++; $display("FAIL b2b_cack0 got=%b exp=1", bus.cack); end
    @(negedge vclk); cmd(1'b1, 32'h0000_5004, 32'h0000_0011); #1;
    checks++; if (bus.cack !== 1'b0 || bus.vpsel !== e_sel || bus.vpaddr !== 32'h1000) begin errors++; $display("FAIL b2b_setup_ignore got=%b/%b/%h exp=0/%b/00001000", bus.cack, bus.vpsel, bus.vpaddr, e_sel); end
    @(negedge vclk); #1;
    checks++; if (bus.cack !== 1'b0 || bus.vpenable !== 1'b1) begin errors++; $display("FAIL b2b_access_ignore got=%b/%b exp=0/1", bus.cack, bus.vpenable); end
    @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.crdata !== 32'hA5 || bus.cack !== 1'b1) begin errors++; $display("FAIL b2b_done_ack got=%b/%h/%b exp=1/000000a5/1", bus.cdone, bus.crdata, bus.cack); end
    e_sel = '0; e_sel[5] = 1'b1;
    @(negedge vclk); bus.creq = 1'b0; #1;
    checks++; if (bus.vpsel !== e_sel || bus.vpwrite !== 1'b1 || bus.vpaddr !== 32'h5004 || bus.vpwdata !== 32'h11) begin errors++; $display("FAIL b2b_setup2 got=%b/%b/%h/%h exp=%b/1/00005004/00000011", bus.vpsel, bus.vpwrite, bus.vpaddr, bus.vpwdata, e_sel); end
    @(negedge vclk); @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b0 || bus.crdata !== 32'hA5) begin errors++; $display("FAIL b2b_done2 got=%b/%b/%h exp=1/0/000000a5", bus.cdone, bus.cerr, bus.crdata); end
  endtask

  task automatic test_async_reset();
    @(negedge vclk); cmd(1'b0, 32'h0000_6000, 32'h0); bus.vpready = 1'b0;
    @(negedge vclk); bus.creq = 1'b0;
    @(negedge vclk); #1;
    checks++; if (bus.vpenable !== 1'b1) begin errors++; $display("FAIL ar_in_access got=%b exp=1", bus.vpenable); end
    #1 vrst = 1'b0; #1;
    checks++; if (bus.vpsel !== 8'h00 || bus.vpenable !== 1'b0 || bus.cdone !== 1'b0) begin errors++; $display("FAIL ar_async got=%b/%b/%b exp=00000000/0/0", bus.vpsel, bus.vpenable, bus.cdone); end
    @(negedge vclk); vrst = 1'b1;
    e_sel = '0; e_sel[0] = 1'b1;
    @(negedge vclk); cmd(1'b0, 32'h0000_0000, 32'h0); bus.vprdata = 32'h77; bus.vpready = 1'b1; #1;
    checks++; if (bus.cack !== 1'b1) begin errors++; $display("FAIL ar_cack got=%b exp=1", bus.cack); end
    @(negedge vclk); bus.creq = 1'b0; #1;
    checks++; if (bus.vpsel !== e_sel || bus.vpenable !== 1'b0) begin errors++; $display("FAIL ar_setup got=%b/%b exp=%b/0", bus.vpsel, bus.vpenable, e_sel); end
    @(negedge vclk); @(negedge vclk); #1;
    checks++; if (bus.cdone !== 1'b1 || bus.cerr !== 1'b0 || bus.crdata !== 32'h77) begin errors++; $display("FAIL ar_done got=%b/%b/%h exp=1/0/00000077", bus.cdone, bus.cerr, bus.crdata); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_decode_error();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
